// File: rtl/fork_pkg.sv
// fork_pkg: default sizes and shared types for the eager fork controller
package fork_pkg;
   localparam int DEFAULT_NUM_READYS = 2;
   localparam int DEFAULT_CNT_W      = 16;
   typedef logic [DEFAULT_NUM_READYS-1:0] fork_mask_t;
endpackage

// File: rtl/fork_done_flag.sv
// fork_done_flag: per-output "token already delivered" flag
//   clk, rst_n : clock, synchronous active-low reset
//   fire       : token retired by the producer this cycle (clears the flag)
//   xfer       : this output accepted the token this cycle (sets the flag)
//   done       : flag state
module fork_done_flag (
   input  logic clk,
   input  logic rst_n,
   input  logic fire,
   input  logic xfer,
   output logic done
);
   logic done_d, done_q;
   always_comb done_d = fire ? 1'b0 : (xfer | done_q);
   always_ff @(posedge clk) done_q <= !rst_n ? 1'b0 : done_d;
   assign done = done_q;
endmodule

// File: rtl/eager_fork_ctrl.sv
// eager_fork_ctrl: one-to-many eager fork sequencer; each enabled output gets the token exactly once
//   clk, rst_n  : clock, synchronous active-low reset
//   valid_in    : producer token valid;  ready_in : producer may retire the token
//   valid_out   : per-consumer valid;    ready_out : per-consumer ready
//   fork_mask   : 1 = output participates in the fork
//   stall_cnt   : saturating count of stalled producer cycles (only with FORK_STALL_CNT_EN)
module eager_fork_ctrl
   import fork_pkg::*;
#(
   parameter int NUM_READYS = DEFAULT_NUM_READYS
`ifdef FORK_STALL_CNT_EN
   , parameter int CNT_W = DEFAULT_CNT_W
`endif
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  valid_in,
   output logic                  ready_in,
   output logic [NUM_READYS-1:0] valid_out,
   input  logic [NUM_READYS-1:0] ready_out,
   input  logic [NUM_READYS-1:0] fork_mask
`ifdef FORK_STALL_CNT_EN
   , output logic [CNT_W-1:0]    stall_cnt
`endif
);
   logic [NUM_READYS-1:0] done, ack;
   logic fire;
   always_comb begin
      valid_out = {NUM_READYS{valid_in}} & fork_mask & ~done;
      ack       = ~fork_mask | done | ready_out;
      ready_in  = 1'b1;
      for (int i = 0; i < NUM_READYS; i++) ready_in = ready_in & ack[i];
      fire      = valid_in & ready_in;
   end
   for (genvar g = 0; g < NUM_READYS; g++) begin : g_done
      fork_done_flag u_done (
         .clk  (clk),
         .rst_n(rst_n),
         .fire (fire),
         .xfer (valid_out[g] & ready_out[g]),
         .done (done[g])
      );
   end
`ifdef FORK_STALL_CNT_EN
   logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;
   always_comb stall_cnt_d = (valid_in & ~ready_in & ~&stall_cnt_q) ? stall_cnt_q + 1'b1 : stall_cnt_q;
   always_ff @(posedge clk) stall_cnt_q <= !rst_n ? '0 : stall_cnt_d;
   assign stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_eager_fork_ctrl.sv
// tb_eager_fork_ctrl: vector-table and scoreboard bench for eager_fork_ctrl (NUM_READYS=3)
module tb_eager_fork_ctrl;
   localparam int N = 3;
`ifdef FORK_STALL_CNT_EN
   localparam int CW = 4;
`endif
   logic clk = 1'b0;
   logic rst_n, valid_in, ready_in;
   logic [N-1:0] valid_out, ready_out, fork_mask;
`ifdef FORK_STALL_CNT_EN
   logic [CW-1:0] stall_cnt;
   logic [CW-1:0] stall_m;
`endif
   always #5 clk = ~clk;

   eager_fork_ctrl #(
      .NUM_READYS(N)
`ifdef FORK_STALL_CNT_EN
      , .CNT_W(CW)
`endif
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .valid_in (valid_in),
      .ready_in (ready_in),
      .valid_out(valid_out),
      .ready_out(ready_out),
      .fork_mask(fork_mask)
`ifdef FORK_STALL_CNT_EN
      , .stall_cnt(stall_cnt)
`endif
   );

   typedef struct {
      logic         rst_n;
      logic         vin;
      logic [N-1:0] mask;
      logic [N-1:0] rdy;
      logic         exp_rin;
      logic [N-1:0] exp_vout;
      logic         chk;
   } vec_t;
   typedef struct {
      logic         rin;
      logic [N-1:0] vout;
      int           idx;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];
   int errors = 0;
   int checks = 0;
   int exp_x[N];
   int act_x[N];

   task automatic add(input logic r, input logic v, input logic [N-1:0] m, input logic [N-1:0] rd,
                      input logic er, input logic [N-1:0] ev, input logic c);
      vecs.push_back('{r, v, m, rd, er, ev, c});
   endtask

   task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s vec %0d: got %0h expected %0h", name, k, act, exp);
      end
   endtask

   initial begin
      exp_t e;
      for (int i = 0; i < N; i++) begin
         exp_x[i] = 0;
         act_x[i] = 0;
      end
`ifdef FORK_STALL_CNT_EN
      stall_m = '0;
`endif
      // reset held two cycles with a pending token
      add(0, 1, 3'b111, 3'b000, 0, 3'b111, 0);
      add(0, 1, 3'b111, 3'b000, 0, 3'b111, 1);
      add(1, 1, 3'b111, 3'b000, 0, 3'b111, 1);
      // simultaneous accept, one token per cycle
      repeat (4) add(1, 1, 3'b111, 3'b111, 1, 3'b111, 1);
      // staggered accept
      add(1, 1, 3'b111, 3'b001, 0, 3'b111, 1);
      add(1, 1, 3'b111, 3'b100, 0, 3'b110, 1);
      add(1, 1, 3'b111, 3'b010, 1, 3'b010, 1);
      add(1, 1, 3'b111, 3'b000, 0, 3'b111, 1);
      add(1, 1, 3'b111, 3'b111, 1, 3'b111, 1);
      // masked outputs
      add(1, 0, 3'b101, 3'b000, 0, 3'b000, 1);
      add(1, 1, 3'b101, 3'b010, 0, 3'b101, 1);
      add(1, 1, 3'b101, 3'b101, 1, 3'b101, 1);
      add(1, 1, 3'b101, 3'b001, 0, 3'b101, 1);
      add(1, 1, 3'b101, 3'b000, 0, 3'b100, 1);
      add(1, 1, 3'b101, 3'b100, 1, 3'b100, 1);
      // empty mask
      add(1, 0, 3'b000, 3'b000, 1, 3'b000, 1);
      add(1, 1, 3'b000, 3'b000, 1, 3'b000, 1);
      add(1, 1, 3'b000, 3'b111, 1, 3'b000, 1);
      // valid dropped mid-token: done is retained
      add(1, 0, 3'b111, 3'b000, 0, 3'b000, 1);
      add(1, 1, 3'b111, 3'b010, 0, 3'b111, 1);
      add(1, 0, 3'b111, 3'b000, 0, 3'b000, 1);
      add(1, 1, 3'b111, 3'b000, 0, 3'b101, 1);
      add(1, 1, 3'b111, 3'b101, 1, 3'b101, 1);
      // reset mid-token re-offers to all outputs
      add(1, 1, 3'b111, 3'b000, 0, 3'b111, 1);
      add(1, 1, 3'b111, 3'b011, 0, 3'b111, 1);
      add(1, 1, 3'b111, 3'b000, 0, 3'b100, 1);
      add(0, 1, 3'b111, 3'b000, 0, 3'b100, 1);
      add(1, 1, 3'b111, 3'b000, 0, 3'b111, 1);
      add(1, 1, 3'b111, 3'b111, 1, 3'b111, 1);
      // long stall drives the counter into saturation, then reset clears it
      repeat (20) add(1, 1, 3'b111, 3'b000, 0, 3'b111, 1);
      add(1, 1, 3'b111, 3'b110, 0, 3'b111, 1);
      add(0, 1, 3'b111, 3'b000, 0, 3'b001, 1);
      add(1, 1, 3'b111, 3'b000, 0, 3'b111, 1);
      add(1, 1, 3'b111, 3'b111, 1, 3'b111, 1);

      foreach (vecs[k]) begin
         rst_n     = vecs[k].rst_n;
         valid_in  = vecs[k].vin;
         fork_mask = vecs[k].mask;
         ready_out = vecs[k].rdy;
         if (vecs[k].chk) sb.push_back('{vecs[k].exp_rin, vecs[k].exp_vout, k});
         #2;
         if (vecs[k].chk) begin
            e = sb.pop_front();
            check("ready_in", e.idx, {31'd0, ready_in}, {31'd0, e.rin});
            check("valid_out", e.idx, {29'd0, valid_out}, {29'd0, e.vout});
`ifdef FORK_STALL_CNT_EN
            check("stall_cnt", e.idx, {28'd0, stall_cnt}, {28'd0, stall_m});
`endif
         end
         if (vecs[k].chk && vecs[k].rst_n)
            for (int i = 0; i < N; i++) begin
               exp_x[i] += int'(vecs[k].exp_vout[i] & vecs[k].rdy[i]);
               act_x[i] += int'(valid_out[i] & ready_out[i]);
            end
`ifdef FORK_STALL_CNT_EN
         if (!vecs[k].rst_n) stall_m = '0;
         else if (vecs[k].vin && !vecs[k].exp_rin && stall_m != '1) stall_m = stall_m + 1'b1;
`endif
         @(posedge clk);
         #1;
      end
      for (int i = 0; i < N; i++) check($sformatf("xfers[%0d]", i), i, act_x[i], exp_x[i]);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
